// File: rtl/riscv_pkg.sv
// Shared RISC-V constants used by the PC pipeline: default XLEN, reset/bubble PCs and instruction sizes.
package riscv_pkg;
    localparam int unsigned XLEN        = 32;
    localparam int unsigned PC_RESET    = 0;
    localparam int unsigned BUBBLE_PC   = 0;
    localparam int unsigned ILEN_BYTES  = 4;
    localparam int unsigned CILEN_BYTES = 2;
endpackage

// File: rtl/pc_stage_reg.sv
// One PC pipeline stage register (pc, valid, optional is_c under PC_PIPE_RVC_EN).
// Priority each cycle: flush > hold > bubble > load.
module pc_stage_reg #(
    parameter int unsigned XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            hold_i,
    input  logic            bubble_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            valid_i,
`ifdef PC_PIPE_RVC_EN
    input  logic            is_c_i,
    output logic            is_c_o,
`endif
    output logic [XLEN-1:0] pc_o,
    output logic            valid_o
);
    import riscv_pkg::*;

    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
`ifdef PC_PIPE_RVC_EN
    logic            is_c_q, is_c_d;
`endif

    // Invalid entries always carry the bubble PC, never a stale value.
    always_comb begin
        pc_d    = pc_q;
        valid_d = valid_q;
`ifdef PC_PIPE_RVC_EN
        is_c_d  = is_c_q;
`endif
        if (flush_i || (!hold_i && bubble_i)) begin
            pc_d    = XLEN'(BUBBLE_PC);
            valid_d = 1'b0;
`ifdef PC_PIPE_RVC_EN
            is_c_d  = 1'b0;
`endif
        end else if (!hold_i) begin
            pc_d    = valid_i ? pc_i : XLEN'(BUBBLE_PC);
            valid_d = valid_i;
`ifdef PC_PIPE_RVC_EN
            is_c_d  = valid_i & is_c_i;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= XLEN'(PC_RESET);
            valid_q <= 1'b0;
`ifdef PC_PIPE_RVC_EN
            is_c_q  <= 1'b0;
`endif
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
`ifdef PC_PIPE_RVC_EN
            is_c_q  <= is_c_d;
`endif
        end
    end

    assign pc_o    = pc_q;
    assign valid_o = valid_q;
`ifdef PC_PIPE_RVC_EN
    assign is_c_o  = is_c_q;
`endif
endmodule

// File: rtl/pc_stage_pipeline.sv
// PC pipeline with per-stage stall/flush, link address for write-back and retired-instruction counter.
// Define PC_PIPE_RVC_EN to carry a compressed-instruction flag per stage (link = pc+2 for RVC).
module pc_stage_pipeline #(
    parameter int unsigned XLEN  = riscv_pkg::XLEN,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [XLEN-1:0]       pc_in,
    input  logic                  pc_valid_in,
`ifdef PC_PIPE_RVC_EN
    input  logic                  is_c_in,
`endif
    input  logic [DEPTH-1:0]      stall,
    input  logic [DEPTH-1:0]      flush,
    output logic [DEPTH*XLEN-1:0] pc_stage,
    output logic [DEPTH-1:0]      valid_stage,
    output logic [XLEN-1:0]       link_wb,
    output logic                  retire,
    output logic [CNT_W-1:0]      instret
);
    import riscv_pkg::*;

    logic [DEPTH-1:0] hold;
    logic [DEPTH-1:0] bubble;
    logic [DEPTH-1:0] valid_src;
    logic [XLEN-1:0]  pc_src [DEPTH];
    logic [XLEN-1:0]  pc_arr [DEPTH];
`ifdef PC_PIPE_RVC_EN
    logic [DEPTH-1:0] is_c_src;
    logic [DEPTH-1:0] is_c_arr;
`endif

    // A stall anywhere downstream freezes this stage; a frozen predecessor feeds a bubble.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        assign hold[i] = |stall[DEPTH-1:i];

        if (i == 0) begin : g_first
            assign bubble[i]    = 1'b0;
            assign pc_src[i]    = pc_in;
            assign valid_src[i] = pc_valid_in;
`ifdef PC_PIPE_RVC_EN
            assign is_c_src[i]  = is_c_in;
`endif
        end else begin : g_rest
            assign bubble[i]    = hold[i-1];
            assign pc_src[i]    = pc_arr[i-1];
            assign valid_src[i] = valid_stage[i-1];
`ifdef PC_PIPE_RVC_EN
            assign is_c_src[i]  = is_c_arr[i-1];
`endif
        end

        pc_stage_reg #(
            .XLEN(XLEN)
        ) u_reg (
            .clk      (clk),
            .rst_n    (rst_n),
            .flush_i  (flush[i]),
            .hold_i   (hold[i]),
            .bubble_i (bubble[i]),
            .pc_i     (pc_src[i]),
            .valid_i  (valid_src[i]),
`ifdef PC_PIPE_RVC_EN
            .is_c_i   (is_c_src[i]),
            .is_c_o   (is_c_arr[i]),
`endif
            .pc_o     (pc_arr[i]),
            .valid_o  (valid_stage[i])
        );

        assign pc_stage[i*XLEN +: XLEN] = pc_arr[i];
    end

`ifdef PC_PIPE_RVC_EN
    assign link_wb = pc_arr[DEPTH-1] +
                     (is_c_arr[DEPTH-1] ? XLEN'(CILEN_BYTES) : XLEN'(ILEN_BYTES));
`else
    assign link_wb = pc_arr[DEPTH-1] + XLEN'(ILEN_BYTES);
`endif

    logic             retire_q, retire_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    // A valid last-stage entry retires when it is replaced rather than held or flushed.
    always_comb begin
        retire_d  = valid_stage[DEPTH-1] & ~hold[DEPTH-1] & ~flush[DEPTH-1];
        instret_d = instret_q + CNT_W'(retire_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_q  <= 1'b0;
            instret_q <= '0;
        end else begin
            retire_q  <= retire_d;
            instret_q <= instret_d;
        end
    end

    assign retire  = retire_q;
    assign instret = instret_q;
endmodule
